// File: rtl/fifo_pdp_pkg.sv
// Shared helpers for buffers built around the pseudo-dual-port SRAM.
//
// Contents:
//   addr_w(depth) : address width for a memory of 'depth' words.
//                   Never returns less than 1.
//   cnt_w(depth)  : width of a counter that spans 0..depth.
package fifo_pdp_pkg;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_pdp_ctrl_if.sv
// Streaming handshake bundle for fifo_pdp_ctrl.
//
// Signals:
//   wr_valid / wr_ready / wr_data : producer side. A push is wr_valid & wr_ready.
//   rd_valid / rd_ready / rd_data : consumer side. A pop is rd_valid & rd_ready.
//
// Modports:
//   master : the producer/consumer pair that connects to the FIFO.
//   slave  : the FIFO itself.
interface fifo_pdp_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/fifo_pdp_mem.sv
// Pseudo-dual-port memory: WIDTH x DEPTH words.
// Port A writes. Port B reads with a registered output.
//
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable
//   raddr : read address
//   rdata : read data, valid one cycle after re; holds its value otherwise
//
// The contents are never reset.
module fifo_pdp_mem
  import fifo_pdp_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_pdp_ctrl.sv
// Synchronous FIFO controller around a pseudo-dual-port SRAM.
//
// The memory has one cycle of read latency. A 2-entry register buffer
// sits on the read side and is prefetched, so that one push and one pop
// can be sustained per cycle. On an empty FIFO, a word appears on rd_data
// two edges after it is pushed.
//
// Ports:
//   clk   : clock, posedge
//   rst   : synchronous active-high reset
//   clr   : synchronous flush. It has the same effect as rst on the
//           controller state, and it drops a push made in the same cycle.
//   bus   : wr_valid/wr_ready/wr_data and rd_valid/rd_ready/rd_data handshakes
//   count : total entries held (memory + read in flight + output buffer)
//   full  : count == DEPTH
//   empty : count == 0
module fifo_pdp_ctrl
  import fifo_pdp_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = addr_w(DEPTH),
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  fifo_pdp_ctrl_if.slave bus,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    mem_cnt;
  logic             rd_pend;
  logic [1:0]       buf_cnt;
  logic [WIDTH-1:0] ob_head;
  logic [WIDTH-1:0] ob_tail;
  logic [WIDTH-1:0] mem_rdata;

  logic             flush;
  logic             push;
  logic             pop;
  logic             issue;
  logic [2:0]       occ;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign flush = rst | clr;

  // Status comes only from registered state. As a result, wr_ready never
  // sees rd_ready, and a pop while full does not open a push slot in the
  // same cycle.
  assign count        = mem_cnt + CW'(rd_pend) + CW'(buf_cnt);
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign bus.wr_ready = ~full;
  assign bus.rd_valid = (buf_cnt != 2'd0);
  assign bus.rd_data  = ob_head;

  assign push = bus.wr_valid & ~full;
  assign pop  = bus.rd_valid & bus.rd_ready;

  // Prefetch while the buffer plus the in-flight read would still hold
  // fewer than two words after this cycle's pop. mem_cnt excludes a push
  // from this same cycle, so a read never targets the word being written.
  assign occ   = 3'(buf_cnt) + 3'(rd_pend);
  assign issue = (mem_cnt != '0) && (occ < (3'd2 + 3'(pop)));

  // ---- stage p0 -> p1: memory access (write port A, read port B) ----
  fifo_pdp_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .re    (issue & ~flush),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // ---- stage p1 -> p2: read return into the output buffer ----
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
      buf_cnt <= 2'd0;
      ob_head <= '0;
      ob_tail <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (issue) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      mem_cnt <= mem_cnt + CW'(push) - CW'(issue);
      rd_pend <= issue;
      buf_cnt <= buf_cnt + 2'(rd_pend) - 2'(pop);

      // A return never meets a full buffer, because the issue rule keeps
      // buf_cnt + rd_pend <= 2. The returned word goes to whichever slot
      // becomes the first free one after the pop.
      if (rd_pend) begin
        if ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop)) begin
          ob_head <= mem_rdata;
        end else begin
          ob_tail <= mem_rdata;
        end
      end else if (pop && (buf_cnt == 2'd2)) begin
        ob_head <= ob_tail;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pdp_ctrl.sv
module tb_fifo_pdp_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  fifo_pdp_ctrl_if #(.WIDTH(WIDTH)) bus ();

  fifo_pdp_ctrl #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. The FIFO is a queue of (data, push edge) pairs.
  // The head word is visible once two edges have passed since its push.
  // While nothing is visible, rd_data holds the last visible word, or 0
  // after a reset or flush.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               e;
  } ent_t;

  ent_t             mq[$];
  int               ecount   = 0;
  logic [WIDTH-1:0] shown    = '0;
  bit               model_ok = 1'b0;

  function automatic bit m_valid();
    return (mq.size() > 0) && (mq[0].e <= ecount - 2);
  endfunction

  always @(posedge clk) begin
    bit   do_push;
    bit   do_pop;
    ent_t ent;
    do_pop  = bus.rd_ready && m_valid();
    do_push = bus.wr_valid && (mq.size() < DEPTH);
    ecount++;
    if (rst || clr) begin
      mq.delete();
      shown    = '0;
      model_ok = 1'b1;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        ent.d = bus.wr_data;
        ent.e = ecount;
        mq.push_back(ent);
      end
      if (m_valid()) shown = mq[0].d;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("m_count",    32'(count),        32'(mq.size()));
      check("m_full",     32'(full),         32'(mq.size() == DEPTH));
      check("m_empty",    32'(empty),        32'(mq.size() == 0));
      check("m_wr_ready", 32'(bus.wr_ready), 32'(mq.size() < DEPTH));
      check("m_rd_valid", 32'(bus.rd_valid), 32'(m_valid()));
      check("m_rd_data",  32'(bus.rd_data),  32'(shown));
    end
  end

  logic [WIDTH-1:0] exp_q[$];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pops words until exp_q has been consumed, checking their order.
  // Called at a negedge; returns at a negedge with rd_ready low.
  task automatic drain(input string name);
    int k      = 0;
    int budget = 0;
    bus.rd_ready = 1'b1;
    while (1) begin
      if (bus.rd_valid) begin
        check(name, 32'(bus.rd_data), 32'(exp_q[k]));
        k++;
      end
      if (k == exp_q.size() || budget == 50) break;
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    bus.rd_ready = 1'b0;
    check({name, "_count"}, 32'(k), 32'(exp_q.size()));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},    32'(count),        32'd0);
    check({tag, "_empty"},    32'(empty),        32'd1);
    check({tag, "_full"},     32'(full),         32'd0);
    check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    check({tag, "_rd_data"},  32'(bus.rd_data),  32'd0);
    check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int budget;
    int first;
    int last;
    int maxc;

    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    rst = 1'b1;
    clr = 1'b0;
    cyc(2);
    rst = 1'b0;
    check_reset_state("reset");

    // Single word: push at E0, visible after E0+2.
    bus.wr_data  = 8'hA5;
    bus.wr_valid = 1'b1;
    cyc(1);
    bus.wr_valid = 1'b0;
    check("single_count_e1", 32'(count),        32'd1);
    check("single_valid_e1", 32'(bus.rd_valid), 32'd0);
    cyc(1);
    check("single_valid_e2", 32'(bus.rd_valid), 32'd0);
    cyc(1);
    check("single_valid_e3", 32'(bus.rd_valid), 32'd1);
    check("single_data",     32'(bus.rd_data),  32'hA5);
    bus.rd_ready = 1'b1;
    cyc(1);
    bus.rd_ready = 1'b0;
    check("single_empty", 32'(empty), 32'd1);

    // Fill to full, then offer a ninth word that must be ignored.
    for (int i = 0; i < 8; i++) begin
      bus.wr_data  = 8'(8'h10 + i);
      bus.wr_valid = 1'b1;
      cyc(1);
    end
    bus.wr_data = 8'hFF;
    check("fill_full",     32'(full),         32'd1);
    check("fill_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("fill_count",    32'(count),        32'd8);
    cyc(2);
    check("fill_ninth_ignored", 32'(count), 32'd8);

    // Full plus pop: the pop happens, the push waits one cycle.
    check("fullpop_head", 32'(bus.rd_data), 32'h10);
    bus.wr_data  = 8'h20;
    bus.rd_ready = 1'b1;
    cyc(1);
    bus.rd_ready = 1'b0;
    check("fullpop_count_7",  32'(count),        32'd7);
    check("fullpop_wr_ready", 32'(bus.wr_ready), 32'd1);
    cyc(1);
    bus.wr_valid = 1'b0;
    check("fullpop_count_8", 32'(count), 32'd8);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20};
    drain("fill_drain");
    check("fill_drain_empty", 32'(empty), 32'd1);

    // Streaming with pointer wrap: 20 back-to-back pushes, always ready.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          bus.wr_data  = 8'(i);
          bus.wr_valid = 1'b1;
          @(negedge clk);
        end
        bus.wr_valid = 1'b0;
      end
      begin
        k = 0; budget = 0; first = -1; last = -1; maxc = 0;
        bus.rd_ready = 1'b1;
        while (1) begin
          if (int'(count) > maxc) maxc = int'(count);
          if (bus.rd_valid) begin
            check("stream_data", 32'(bus.rd_data), 32'(k));
            if (first < 0) first = budget;
            last = budget;
            k++;
          end
          if (k == 20 || budget == 80) break;
          @(negedge clk);
          budget++;
        end
        @(negedge clk);
        bus.rd_ready = 1'b0;
        check("stream_words",    32'(k),          32'd20);
        check("stream_gapless",  32'(last - first), 32'd19);
        check("stream_count_le3", 32'(maxc <= 3),  32'd1);
      end
    join

    // Flush with a push offered in the same cycle.
    for (int i = 0; i < 5; i++) begin
      bus.wr_data  = 8'(8'h40 + i);
      bus.wr_valid = 1'b1;
      cyc(1);
    end
    check("flush_pre_count", 32'(count), 32'd5);
    bus.wr_data = 8'h99;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    bus.wr_valid = 1'b0;
    check_reset_state("flush");
    cyc(1);
    check("flush_push_dropped", 32'(count), 32'd0);
    bus.wr_data  = 8'h3C;
    bus.wr_valid = 1'b1;
    cyc(1);
    bus.wr_valid = 1'b0;
    budget = 0;
    while (!bus.rd_valid && budget < 10) begin
      cyc(1);
      budget++;
    end
    check("flush_after_valid", 32'(bus.rd_valid), 32'd1);
    check("flush_after_data",  32'(bus.rd_data),  32'h3C);
    check("flush_after_count", 32'(count),        32'd1);
    exp_q = '{8'h3C};
    drain("flush_drain");

    // Reset in the middle of traffic.
    bus.wr_valid = 1'b1;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = 8'(8'h55 + i);
      cyc(1);
    end
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check_reset_state("midreset");
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
